// File: rtl/xor_mpm_rw.sv
// XOR-based multi-port RAM: WPORTS writes and RPORTS reads every cycle, built from 1W1R copies,
// with a two-stage write pipeline, read bypass, same-address arbitration and a clear sweep.
module xor_mpm_rw #(
   parameter  int WIDTH  = 8,
   parameter  int DEPTH  = 256,
   parameter  int WPORTS = 2,
   parameter  int RPORTS = 2,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clr_req,
   output logic                         ready,
   input  logic [WPORTS-1:0][AW-1:0]    waddr,
   input  logic [WPORTS-1:0][WIDTH-1:0] wdata,
   input  logic [WPORTS-1:0]            wen,
   input  logic [RPORTS-1:0][AW-1:0]    raddr,
   input  logic [RPORTS-1:0]            ren,
   output logic [RPORTS-1:0][WIDTH-1:0] q,
   output logic [WPORTS-1:0]            wr_conflict
);

   localparam int            NCOPY = WPORTS - 1 + RPORTS;
   localparam int            WORDS = 1 << AW;
   localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

   typedef enum logic {S_CLEAR = 1'b0, S_READY = 1'b1} state_e;

   state_e                                   state_q, state_d;
   logic [AW-1:0]                            cnt_q, cnt_d;
   logic                                     clr_we;
   logic                                     accept;

   logic [WPORTS-1:0]                        s0_v_q, s0_v_d;
   logic [WPORTS-1:0][AW-1:0]                s0_addr_q;
   logic [WPORTS-1:0][WIDTH-1:0]             s0_data_q;
   logic [WPORTS-1:0][WPORTS-1:0][WIDTH-1:0] s0_rd_q, s0_rd_d;
   logic [WPORTS-1:0]                        drop;
   logic [WPORTS-1:0]                        conf_q, conf_d;
   logic [RPORTS-1:0][WIDTH-1:0]             q_q, q_d;
   logic [WIDTH-1:0]                         rsum;

   logic [WPORTS-1:0]                        pend_v;
   logic [WPORTS-1:0][WIDTH-1:0]             pend_d;
   logic [WPORTS-1:0]                        grp_we;
   logic [WPORTS-1:0][AW-1:0]                grp_wa;
   logic [WPORTS-1:0][WIDTH-1:0]             grp_wd;
   logic [WIDTH-1:0]                         cp_rd [WPORTS][NCOPY];

   // Clear sequencer: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_CLEAR: begin
            cnt_d = cnt_q + AW'(1);
            if (cnt_q == LAST) begin
               state_d = S_READY;
               cnt_d   = '0;
            end
         end
         S_READY: begin
            if (clr_req) begin
               state_d = S_CLEAR;
               cnt_d   = '0;
            end
         end
         default: state_d = S_CLEAR;
      endcase
   end

   // A clear request blocks new accesses on its own edge; the pipeline drains that same edge.
   always_comb begin
      ready  = (state_q == S_READY);
      clr_we = (state_q == S_CLEAR);
      accept = (state_q == S_READY) && !clr_req;
   end

   // Stage-1 commit: s0_rd_q[g][g] is always zero, so folding it into the XOR is harmless.
   always_comb begin
      for (int g = 0; g < WPORTS; g++) begin
         pend_d[g] = s0_data_q[g];
         for (int j = 0; j < WPORTS; j++) pend_d[g] = pend_d[g] ^ s0_rd_q[g][j];
         pend_v[g] = s0_v_q[g] && (state_q == S_READY);
         grp_we[g] = clr_we || pend_v[g];
         grp_wa[g] = clr_we ? cnt_q : s0_addr_q[g];
         grp_wd[g] = clr_we ? '0 : pend_d[g];
      end
   end

   // Copy c of group g: copies below WPORTS-1 serve the other write ports, the rest serve reads.
   // Storage covers the full 2**AW space so out-of-range writes land in words nobody owns.
   for (genvar g = 0; g < WPORTS; g++) begin : g_grp
      for (genvar c = 0; c < NCOPY; c++) begin : g_cp
         logic [WIDTH-1:0] mem [WORDS];
         logic [AW-1:0]    rd_a;
         if (c < WPORTS - 1) begin : g_wuser
            assign rd_a = waddr[(c < g) ? c : c + 1];
         end else begin : g_ruser
            assign rd_a = raddr[c - (WPORTS - 1)];
         end
         always_ff @(posedge clk) begin
            if (grp_we[g]) mem[grp_wa[g]] <= grp_wd[g];
         end
         assign cp_rd[g][c] = mem[rd_a];
      end
   end

   // Stage 0: arbitration plus other-group reads, forwarding a same-address commit in flight.
   always_comb begin
      drop    = '0;
      s0_v_d  = '0;
      conf_d  = '0;
      s0_rd_d = '0;
      for (int w = 0; w < WPORTS; w++) begin
         for (int k = 0; k < w; k++)
            if (wen[k] && (waddr[k] == waddr[w])) drop[w] = 1'b1;
         s0_v_d[w] = accept && wen[w] && !drop[w];
         conf_d[w] = accept && wen[w] && drop[w];
         for (int j = 0; j < WPORTS; j++) begin
            if (j != w) begin
               if (pend_v[j] && (s0_addr_q[j] == waddr[w])) s0_rd_d[w][j] = pend_d[j];
               else s0_rd_d[w][j] = cp_rd[j][(w < j) ? w : w - 1];
            end
         end
      end
   end

   always_comb begin
      q_d  = q_q;
      rsum = '0;
      for (int r = 0; r < RPORTS; r++) begin
         rsum = '0;
         for (int g = 0; g < WPORTS; g++) begin
            if (pend_v[g] && (s0_addr_q[g] == raddr[r])) rsum = rsum ^ pend_d[g];
            else rsum = rsum ^ cp_rd[g][WPORTS - 1 + r];
         end
         if (!accept) q_d[r] = '0;
         else if (ren[r]) q_d[r] = rsum;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0_v_q    <= '0;
         s0_addr_q <= '0;
         s0_data_q <= '0;
         s0_rd_q   <= '0;
         conf_q    <= '0;
         q_q       <= '0;
      end else begin
         s0_v_q    <= s0_v_d;
         s0_addr_q <= waddr;
         s0_data_q <= wdata;
         s0_rd_q   <= s0_rd_d;
         conf_q    <= conf_d;
         q_q       <= q_d;
      end
   end

   assign q           = q_q;
   assign wr_conflict = conf_q;

endmodule
